ex_fwd_ctrl: RTL

- Producer side of the EX-stage forwarding interface.
- Tracks destination registers of in-flight instructions in EX, MEM and WB.
- Generates registered rs1/rs2 forward selects (mem_to_ex_*, wb_to_ex_*) aligned with the DE/EX pipeline register.
- Detects load-use hazards and inserts a one-cycle bubble.

---
 rtl/ex_fwd_ctrl_if.sv | 49 ++++
 rtl/ex_fwd_ctrl.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/ex_fwd_ctrl_if.sv
// ex_fwd_ctrl_if: bundle between the decode/pipeline control logic and the
// EX-stage forwarding controller. The master drives the DE-stage instruction
// description and pipeline controls; the slave (ex_fwd_ctrl) returns the
// registered forward selects and the combinational load-use stall.
// Optional statistics counters appear when FWD_STATS_EN is defined.
interface ex_fwd_ctrl_if #(
  parameter int REG_IDX_W = 5,
  parameter int CNT_W     = 32
);
  logic                 de_valid;
  logic [REG_IDX_W-1:0] de_rs1;
  logic [REG_IDX_W-1:0] de_rs2;
  logic                 de_use_rs1;
  logic                 de_use_rs2;
  logic [REG_IDX_W-1:0] de_rd;
  logic                 de_wr;
  logic                 de_is_load;
  logic                 freeze;
  logic                 flush;
  logic                 mem_to_ex_fwd1;
  logic                 mem_to_ex_fwd2;
  logic                 wb_to_ex_fwd1;
  logic                 wb_to_ex_fwd2;
  logic                 load_use_stall;
`ifdef FWD_STATS_EN
  logic [CNT_W-1:0]     stall_cnt;
  logic [CNT_W-1:0]     fwd_cnt;
`endif

  modport master (
    output de_valid, de_rs1, de_rs2, de_use_rs1, de_use_rs2,
    output de_rd, de_wr, de_is_load, freeze, flush,
    input  mem_to_ex_fwd1, mem_to_ex_fwd2, wb_to_ex_fwd1, wb_to_ex_fwd2,
    input  load_use_stall
`ifdef FWD_STATS_EN
    , input stall_cnt, fwd_cnt
`endif
  );

  modport slave (
    input  de_valid, de_rs1, de_rs2, de_use_rs1, de_use_rs2,
    input  de_rd, de_wr, de_is_load, freeze, flush,
    output mem_to_ex_fwd1, mem_to_ex_fwd2, wb_to_ex_fwd1, wb_to_ex_fwd2,
    output load_use_stall
`ifdef FWD_STATS_EN
    , output stall_cnt, fwd_cnt
`endif
  );
endinterface

// File: rtl/ex_fwd_ctrl.sv
// ex_fwd_ctrl: producer side of the EX-stage forwarding logic.
// Keeps a three-deep window (EX, MEM, WB) of in-flight destination registers,
// produces registered rs1/rs2 forward selects that line up with the DE/EX
// pipeline register, and raises a combinational load-use stall that turns
// the next EX entry into a bubble.
// Optional feature macro: FWD_STATS_EN adds saturating stall_cnt / fwd_cnt.
module ex_fwd_ctrl #(
  parameter int REG_IDX_W = 5,
  parameter int CNT_W     = 32
) (
  input logic         clk,
  input logic         rst,
  ex_fwd_ctrl_if.slave bus
);

  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] rd;
    logic                 wr;
    logic                 is_load;
  } slot_t;

  localparam int EX  = 0;
  localparam int MEM = 1;
  localparam int WB  = 2;

  // Reject nonsensical widths at elaboration time.
  if (REG_IDX_W < 1 || CNT_W < 1) begin : g_param_check
    $error("ex_fwd_ctrl: REG_IDX_W and CNT_W must be at least 1");
  end

  // WB is kept only to complete the window; regfile write-through covers it.
  slot_t slot [3];

  logic  mem_fwd1_q, mem_fwd2_q, wb_fwd1_q, wb_fwd2_q;
  logic  mem_fwd1_d, mem_fwd2_d, wb_fwd1_d, wb_fwd2_d;
  logic  ex_writes, mem_writes;
  logic  rs1_hits_ex, rs2_hits_ex;
  logic  stall;
  logic  advance;
  slot_t de_slot;

  // x0 is hardwired zero, so it never counts as a real producer.
  assign ex_writes  = slot[EX].valid  && slot[EX].wr  && (slot[EX].rd  != '0);
  assign mem_writes = slot[MEM].valid && slot[MEM].wr && (slot[MEM].rd != '0);

  assign rs1_hits_ex = bus.de_use_rs1 && (bus.de_rs1 == slot[EX].rd);
  assign rs2_hits_ex = bus.de_use_rs2 && (bus.de_rs2 == slot[EX].rd);

  // A load in EX cannot forward yet; a redirect or freeze overrides the stall.
  assign stall = bus.de_valid && ex_writes && slot[EX].is_load &&
                 (rs1_hits_ex || rs2_hits_ex) && !bus.flush && !bus.freeze;

  assign advance = !bus.freeze && !bus.flush && !stall;

  assign de_slot = '{valid:   bus.de_valid,
                     rd:      bus.de_rd,
                     wr:      bus.de_wr,
                     is_load: bus.de_is_load};

  // Next-cycle selects for the DE instruction; the newest producer (MEM) wins.
  always_comb begin
    mem_fwd1_d = 1'b0;
    mem_fwd2_d = 1'b0;
    wb_fwd1_d  = 1'b0;
    wb_fwd2_d  = 1'b0;
    mem_fwd1_d = bus.de_valid && bus.de_use_rs1 && ex_writes &&
                 (bus.de_rs1 == slot[EX].rd);
    mem_fwd2_d = bus.de_valid && bus.de_use_rs2 && ex_writes &&
                 (bus.de_rs2 == slot[EX].rd);
    wb_fwd1_d  = bus.de_valid && bus.de_use_rs1 && mem_writes &&
                 (bus.de_rs1 == slot[MEM].rd) && !mem_fwd1_d;
    wb_fwd2_d  = bus.de_valid && bus.de_use_rs2 && mem_writes &&
                 (bus.de_rs2 == slot[MEM].rd) && !mem_fwd2_d;
  end

  // Pipeline window and select registers: freeze > flush > stall > advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        slot[i] <= '0;
      end
      mem_fwd1_q <= 1'b0;
      mem_fwd2_q <= 1'b0;
      wb_fwd1_q  <= 1'b0;
      wb_fwd2_q  <= 1'b0;
    end else if (bus.freeze) begin
      for (int i = 0; i < 3; i++) begin
        slot[i] <= slot[i];
      end
    end else if (bus.flush || stall) begin
      slot[WB]   <= slot[MEM];
      slot[MEM]  <= slot[EX];
      slot[EX]   <= '0;
      mem_fwd1_q <= 1'b0;
      mem_fwd2_q <= 1'b0;
      wb_fwd1_q  <= 1'b0;
      wb_fwd2_q  <= 1'b0;
    end else begin
      slot[WB]   <= slot[MEM];
      slot[MEM]  <= slot[EX];
      slot[EX]   <= de_slot;
      mem_fwd1_q <= mem_fwd1_d;
      mem_fwd2_q <= mem_fwd2_d;
      wb_fwd1_q  <= wb_fwd1_d;
      wb_fwd2_q  <= wb_fwd2_d;
    end
  end

  assign bus.mem_to_ex_fwd1 = mem_fwd1_q;
  assign bus.mem_to_ex_fwd2 = mem_fwd2_q;
  assign bus.wb_to_ex_fwd1  = wb_fwd1_q;
  assign bus.wb_to_ex_fwd2  = wb_fwd2_q;
  assign bus.load_use_stall = stall;

`ifdef FWD_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q, fwd_cnt_q;
  logic             any_fwd_d;

  assign any_fwd_d = mem_fwd1_d || mem_fwd2_d || wb_fwd1_d || wb_fwd2_d;

  // Saturating event counters; stall already excludes freeze, fwd needs advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      if (stall && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (advance && any_fwd_d && (fwd_cnt_q != '1)) begin
        fwd_cnt_q <= fwd_cnt_q + 1'b1;
      end
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.fwd_cnt   = fwd_cnt_q;
`else
  logic unused_advance;
  assign unused_advance = advance;
`endif

endmodule
